// File: rtl/serseq_pkg.sv
// Shared definitions for the serial adder sequencer.
// State encoding and counter sizing helper.
package serseq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serseq_shift_reg.sv
// Right-shifting register with parallel load and serial input.
// Serves as PISO for operands and SIPO for the serial sum.
module serseq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         sin_i,
    input  logic [W-1:0] pin_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = pin_i;
        end else if (shift_i) begin
            sh_d = {sin_i, sh_q[W-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/serial_adder_sequencer.sv
// Parallel-side sequencer for a bit-serial Mealy adder.
// Optional SERSEQ_CARRY_OUT_EN adds a FLUSH cycle capturing the carry-out.
module serial_adder_sequencer
    import serseq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic             x,
    output logic             y,
    output logic             add_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int CW = cnt_w(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH-1:0] a_q, b_q, sum_sh_q;
    logic             load, shift_en, last;
    logic             unused_bits;

    assign load     = (state_q == ST_IDLE) && start;
    assign shift_en = (state_q == ST_SHIFT);
    assign last     = shift_en && (cnt_q == CW'(WIDTH - 1));

    serseq_shift_reg #(.W(WIDTH)) u_a_sh (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (load),
        .shift_i (shift_en),
        .sin_i   (1'b0),
        .pin_i   (a),
        .q_o     (a_q)
    );

    serseq_shift_reg #(.W(WIDTH)) u_b_sh (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (load),
        .shift_i (shift_en),
        .sin_i   (1'b0),
        .pin_i   (b),
        .q_o     (b_q)
    );

    serseq_shift_reg #(.W(WIDTH)) u_sum_sh (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (1'b0),
        .shift_i (shift_en),
        .sin_i   (s),
        .pin_i   ('0),
        .q_o     (sum_sh_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
`ifdef SERSEQ_CARRY_OUT_EN
            ST_SHIFT: if (last) state_d = ST_FLUSH;
`else
            ST_SHIFT: if (last) state_d = ST_DONE;
`endif
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The final sum bit arrives on s in the same cycle the result is latched.
    always_comb begin
        sum_d = sum_q;
`ifdef SERSEQ_CARRY_OUT_EN
        if (state_q == ST_FLUSH) begin
            sum_d = {s, sum_sh_q};
        end
`else
        if (last) begin
            sum_d = {1'b0, s, sum_sh_q[WIDTH-1:1]};
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign x       = shift_en & a_q[0];
    assign y       = shift_en & b_q[0];
    assign add_clr = shift_en | (state_q == ST_FLUSH);
    assign busy    = add_clr;
    assign done    = (state_q == ST_DONE);
    assign sum     = sum_q;

`ifdef SERSEQ_CARRY_OUT_EN
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};
`else
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], sum_sh_q[0]};
`endif

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Self-checking bench: serial adder sequencer driving a serial adder model.
// Expected sums come from plain integer addition of the operands.
module tb_serial_adder_sequencer;

    localparam int W = 4;
`ifdef SERSEQ_CARRY_OUT_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         s, x, y, add_clr, busy, done;
    logic [W:0]   sum;
    logic         c_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    serial_adder_sequencer #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .s       (s),
        .x       (x),
        .y       (y),
        .add_clr (add_clr),
        .busy    (busy),
        .done    (done),
        .sum     (sum)
    );

    // Bit-serial Mealy adder partner.
    always @(posedge clock or negedge reset) begin
        if (!reset)        c_q <= 1'b0;
        else if (!add_clr) c_q <= 1'b0;
        else               c_q <= (x & y) | (x & c_q) | (y & c_q);
    end
    assign s = x ^ y ^ c_q;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] av, input logic [W-1:0] bv);
        int t;
        t = int'(av) + int'(bv);
        if (FL == 0) t = t % (1 << W);
        return (W+1)'(t);
    endfunction

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int restart_at, output logic [W:0] res,
                         output int lat, output logic [W-1:0] xs,
                         output logic [W-1:0] ys, output bit tmo);
        int k;
        k = 0; xs = '0; ys = '0; lat = 0;
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        while (!done && lat < 40) begin
            if (busy && k < W) begin
                xs[k] = x; ys[k] = y; k++;
            end
            if (lat == restart_at) begin
                a = W'(9); b = ~bv; start = 1'b1;
            end else if (lat == restart_at + 1) begin
                start = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        tmo = !done;
        res = sum;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({x, y, add_clr, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got x,y,clr,busy,done=%b want 00000",
                     {x, y, add_clr, busy, done});
        end
        n_checks++;
        if (sum !== '0) begin
            n_fail++;
            $display("FAIL reset_sum got %b want 0", sum);
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({busy, done, add_clr} !== 3'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy,done,clr=%b want 000",
                     {busy, done, add_clr});
        end
    endtask

    task automatic test_basic();
        logic [W:0] res; int lat; logic [W-1:0] xs, ys; bit tmo;
        do_op(4'd3, 4'd5, -1, res, lat, xs, ys, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin
            n_fail++; $display("FAIL basic_timeout got %0d want 0", tmo);
        end
        n_checks++;
        if (xs !== 4'b0011) begin
            n_fail++; $display("FAIL basic_x_stream got %b want 0011", xs);
        end
        n_checks++;
        if (ys !== 4'b0101) begin
            n_fail++; $display("FAIL basic_y_stream got %b want 0101", ys);
        end
        n_checks++;
        if (lat !== W + FL) begin
            n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, W + FL);
        end
        n_checks++;
        if (res !== 5'b01000) begin
            n_fail++; $display("FAIL basic_sum got %b want 01000", res);
        end
        @(negedge clock);
        n_checks++;
        if ({done, busy} !== 2'b00 || sum !== 5'b01000) begin
            n_fail++;
            $display("FAIL basic_after got done,busy=%b sum=%b want 00 01000",
                     {done, busy}, sum);
        end
    endtask

    task automatic test_wrap();
        logic [W:0] res; int lat; logic [W-1:0] xs, ys; bit tmo;
        do_op(4'd15, 4'd1, -1, res, lat, xs, ys, tmo);
        n_checks++;
        if (res !== ref_sum(4'd15, 4'd1)) begin
            n_fail++;
            $display("FAIL wrap_sum got %b want %b", res, ref_sum(4'd15, 4'd1));
        end
        n_checks++;
        if (lat !== W + FL || tmo) begin
            n_fail++; $display("FAIL wrap_latency got %0d want %0d", lat, W + FL);
        end
    endtask

    task automatic test_ignore_start();
        logic [W:0] res; int lat; logic [W-1:0] xs, ys; bit tmo;
        do_op(4'd6, 4'd5, 2, res, lat, xs, ys, tmo);
        n_checks++;
        if (res !== ref_sum(4'd6, 4'd5) || tmo) begin
            n_fail++;
            $display("FAIL ignore_sum got %b want %b", res, ref_sum(4'd6, 4'd5));
        end
        n_checks++;
        if (xs !== 4'd6 || ys !== 4'd5) begin
            n_fail++;
            $display("FAIL ignore_streams got x=%b y=%b want 0110 0101", xs, ys);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_no_queue got busy,done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_mid_reset();
        logic [W:0] res; int lat; logic [W-1:0] xs, ys; bit tmo;
        @(negedge clock);
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, add_clr, x, y, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl got busy,clr,x,y,done=%b want 00000",
                     {busy, add_clr, x, y, done});
        end
        n_checks++;
        if (sum !== '0) begin
            n_fail++; $display("FAIL midreset_sum got %b want 0", sum);
        end
        @(negedge clock);
        reset = 1'b1;
        do_op(4'd6, 4'd7, -1, res, lat, xs, ys, tmo);
        n_checks++;
        if (res !== 5'b01101 || tmo) begin
            n_fail++; $display("FAIL midreset_next_sum got %b want 01101", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] expq[$];
        logic [W:0] exp_v;
        int edge_n, last_done, got;
        edge_n = 0; last_done = -1; got = 0;
        @(negedge clock);
        a = W'($urandom); b = W'($urandom);
        expq.push_back(ref_sum(a, b));
        start = 1'b1;
        while (got < 4 && edge_n < 80) begin
            @(posedge clock);
            edge_n++;
            @(negedge clock);
            if (done) begin
                exp_v = expq.pop_front();
                n_checks++;
                if (sum !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_sum[%0d] got %b want %b", got, sum, exp_v);
                end
                if (last_done >= 0) begin
                    n_checks++;
                    if (edge_n - last_done !== W + 2 + FL) begin
                        n_fail++;
                        $display("FAIL b2b_period got %0d want %0d",
                                 edge_n - last_done, W + 2 + FL);
                    end
                end
                last_done = edge_n;
                got++;
                a = W'($urandom); b = W'($urandom);
                expq.push_back(ref_sum(a, b));
            end
        end
        start = 1'b0;
        n_checks++;
        if (got !== 4) begin
            n_fail++; $display("FAIL b2b_count got %0d want 4", got);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        logic [W:0] res; int lat; logic [W-1:0] xs, ys, av, bv; bit tmo;
        for (int i = 0; i < 8; i++) begin
            av = W'($urandom); bv = W'($urandom);
            do_op(av, bv, -1, res, lat, xs, ys, tmo);
            n_checks++;
            if (res !== ref_sum(av, bv) || lat !== W + FL || tmo) begin
                n_fail++;
                $display("FAIL rand_op[%0d] %0d+%0d got sum=%b lat=%0d want %b lat=%0d",
                         i, av, bv, res, lat, ref_sum(av, bv), W + FL);
            end
            n_checks++;
            if (xs !== av || ys !== bv) begin
                n_fail++;
                $display("FAIL rand_streams[%0d] got x=%b y=%b want %b %b",
                         i, xs, ys, av, bv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
